ahb_bus_arbiter: RTL



---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_rr_picker.sv | 41 ++++
 rtl/ahb_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions used by the bus arbiter and its round-robin picker:
//   - htrans_e / hburst_e / hresp_e : AHB bus encodings
//   - burst_beats()                 : beat count of a burst type (INCR/SINGLE -> 1)
//   - AHB_MAX_MASTERS               : largest supported master count
// -----------------------------------------------------------------------------
package ahb_pkg;

   localparam int AHB_MAX_MASTERS = 16;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'd0,
      HB_INCR   = 3'd1,
      HB_WRAP4  = 3'd2,
      HB_INCR4  = 3'd3,
      HB_WRAP8  = 3'd4,
      HB_INCR8  = 3'd5,
      HB_WRAP16 = 3'd6,
      HB_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      HR_OKAY  = 2'd0,
      HR_ERROR = 2'd1,
      HR_RETRY = 2'd2,
      HR_SPLIT = 2'd3
   } hresp_e;

   // Undefined-length INCR reports 1: it has no fixed end to protect.
   function automatic logic [4:0] burst_beats(input hburst_e b);
      case (b)
         HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
         HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
         HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
         default:              burst_beats = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// -----------------------------------------------------------------------------
// ahb_rr_picker
// Combinational round-robin picker. Searches the eligible vector starting one
// position after ptr, wrapping, so ptr itself is found last.
// Ports:
//   eligible   in  N      candidate requesters
//   ptr        in  IDX_W  last winner
//   any        out 1      at least one eligible requester
//   win_onehot out N      one-hot winner (all zero when any=0)
//   win_idx    out IDX_W  winner index (zero when any=0)
// -----------------------------------------------------------------------------
module ahb_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [N-1:0]     win_onehot,
   output logic [IDX_W-1:0] win_idx
);

   always_comb begin
      any        = 1'b0;
      win_onehot = '0;
      win_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (int'(ptr) + k) % N;
         // Inner loop keeps every bit select constant after unrolling.
         for (int j = 0; j < N; j++) begin
            if (!any && (j == c) && eligible[j]) begin
               any           = 1'b1;
               win_onehot[j] = 1'b1;
               win_idx       = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_bus_arbiter
// AHB Full multi-master arbiter: round-robin grant, fixed bursts never broken,
// locked sequences never interrupted, parks on DEFAULT_MASTER when idle.
// Optional SPLIT support is compiled in with `define AHB_ARB_SPLIT_EN.
// Ports:
//   HCLK       in  1          bus clock
//   HRESET     in  1          asynchronous active-high reset
//   HBUSREQ    in  NUM_M      per-master bus request
//   HLOCK      in  NUM_M      per-master locked-access request
//   HTRANS     in  2          muxed transfer type
//   HBURST     in  3          muxed burst type
//   HREADY     in  1          global ready
//   HRESP      in  2          (AHB_ARB_SPLIT_EN) muxed slave response
//   HSPLIT     in  NUM_M      (AHB_ARB_SPLIT_EN) split-release per master
//   HGRANT     out NUM_M      one-hot grant
//   HMASTER    out HMASTER_W  address-phase owner
//   HMASTLOCK  out 1          current address phase is locked
// -----------------------------------------------------------------------------
module ahb_bus_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_M          = 4,
   parameter int HMASTER_W      = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_M-1:0]     HBUSREQ,
   input  logic [NUM_M-1:0]     HLOCK,
   input  logic [1:0]           HTRANS,
   input  logic [2:0]           HBURST,
   input  logic                 HREADY,
`ifdef AHB_ARB_SPLIT_EN
   input  logic [1:0]           HRESP,
   input  logic [NUM_M-1:0]     HSPLIT,
`endif
   output logic [NUM_M-1:0]     HGRANT,
   output logic [HMASTER_W-1:0] HMASTER,
   output logic                 HMASTLOCK
);

   localparam logic [NUM_M-1:0]     DEF_GRANT = NUM_M'(1) << DEFAULT_MASTER;
   localparam logic [HMASTER_W-1:0] DEF_IDX   = HMASTER_W'(DEFAULT_MASTER);

   logic [NUM_M-1:0]     hgrant_q,     hgrant_d;
   logic [HMASTER_W-1:0] hmaster_q,    hmaster_d;
   logic                 hmastlock_q,  hmastlock_d;
   logic [4:0]           beats_left_q, beats_left_d;
   logic [HMASTER_W-1:0] rr_ptr_q,     rr_ptr_d;

   htrans_e              tr;
   hburst_e              bu;
   logic [HMASTER_W-1:0] grant_idx;
   logic                 lock_cur, lock_next, lock_hold;
   logic                 arb_point, arb_ok, rearb;
   logic [NUM_M-1:0]     split_mask, split_set, eligible;
   logic                 split_hit;
   logic                 pick_any;
   logic [NUM_M-1:0]     pick_oh;
   logic [HMASTER_W-1:0] pick_idx;

   assign tr = htrans_e'(HTRANS);
   assign bu = hburst_e'(HBURST);

   // Decode owner index and lock bits without variable bit selects.
   always_comb begin
      grant_idx = '0;
      lock_cur  = 1'b0;
      lock_next = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (hgrant_q[i]) begin
            grant_idx = HMASTER_W'(i);
            lock_next = HLOCK[i];
         end
         if (hmaster_q == HMASTER_W'(i)) lock_cur = HLOCK[i];
      end
   end

   assign lock_hold = hmastlock_q & lock_cur;

   // Undefined INCR may be re-arbitrated on every accepted beat.
   assign arb_point = (tr == HT_IDLE)
                    | ((tr == HT_NONSEQ) & ((bu == HB_SINGLE) | (bu == HB_INCR)))
                    | ((tr == HT_SEQ) & (beats_left_q == 5'd1))
                    | ((tr == HT_SEQ) & (bu == HB_INCR));
   assign arb_ok    = HREADY & ~lock_hold & arb_point;

`ifdef AHB_ARB_SPLIT_EN
   logic [NUM_M-1:0]     split_mask_q, split_mask_d;
   logic [HMASTER_W-1:0] dmaster_q,    dmaster_d;

   assign split_hit  = HREADY & (hresp_e'(HRESP) == HR_SPLIT);
   assign split_mask = split_mask_q;
   assign dmaster_d  = HREADY ? hmaster_q : dmaster_q;

   always_comb begin
      split_set = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (split_hit && (dmaster_q == HMASTER_W'(i))) split_set[i] = 1'b1;
      end
      // A release beats a new split for the same master.
      split_mask_d = (split_mask_q | split_set) & ~HSPLIT;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         split_mask_q <= '0;
         dmaster_q    <= DEF_IDX;
      end else begin
         split_mask_q <= split_mask_d;
         dmaster_q    <= dmaster_d;
      end
   end
`else
   assign split_hit  = 1'b0;
   assign split_set  = '0;
   assign split_mask = '0;
`endif

   // The split master is excluded already on the edge that splits it.
   assign eligible = HBUSREQ & ~(split_mask | split_set);
   // A SPLIT forces the grant away regardless of burst or lock.
   assign rearb    = arb_ok | split_hit;

   ahb_rr_picker #(
      .N     (NUM_M),
      .IDX_W (HMASTER_W)
   ) u_picker (
      .eligible   (eligible),
      .ptr        (rr_ptr_q),
      .any        (pick_any),
      .win_onehot (pick_oh),
      .win_idx    (pick_idx)
   );

   always_comb begin
      hgrant_d     = hgrant_q;
      rr_ptr_d     = rr_ptr_q;
      hmaster_d    = hmaster_q;
      hmastlock_d  = hmastlock_q;
      beats_left_d = beats_left_q;
      if (rearb) begin
         hgrant_d = pick_any ? pick_oh  : DEF_GRANT;
         rr_ptr_d = pick_any ? pick_idx : DEF_IDX;
      end
      if (HREADY) begin
         hmaster_d   = grant_idx;
         hmastlock_d = lock_next;
         case (tr)
            HT_NONSEQ: beats_left_d = burst_beats(bu) - 5'd1;
            HT_SEQ:    if (beats_left_q != 5'd0) beats_left_d = beats_left_q - 5'd1;
            HT_IDLE:   beats_left_d = 5'd0;
            default:   beats_left_d = beats_left_q;
         endcase
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hgrant_q     <= DEF_GRANT;
         hmaster_q    <= DEF_IDX;
         hmastlock_q  <= 1'b0;
         beats_left_q <= 5'd0;
         rr_ptr_q     <= DEF_IDX;
      end else begin
         hgrant_q     <= hgrant_d;
         hmaster_q    <= hmaster_d;
         hmastlock_q  <= hmastlock_d;
         beats_left_q <= beats_left_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign HGRANT    = hgrant_q;
   assign HMASTER   = hmaster_q;
   assign HMASTLOCK = hmastlock_q;

endmodule
